// File: rtl/referee_1_pkg.sv
// Shared definitions for the referee arbiter slice: line geometry, FSM encoding
// and traffic-class indices (the class indices are also used by referee_2 routing).
package referee_1_pkg;

    localparam int LINE_SIZE = 12;
    localparam int NUM_IN    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam logic [1:0] CLS_POSTED     = 2'd0;
    localparam logic [1:0] CLS_NONPOSTED  = 2'd1;
    localparam logic [1:0] CLS_COMPLETION = 2'd2;
    localparam logic [1:0] CLS_OTHER      = 2'd3;

    // Next input index after idx, wrapping 3 -> 0.
    function automatic logic [1:0] wrap_inc(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/referee_1_rr_arbiter_4.sv
// Four-way request arbiter producing a one-hot grant and its index.
// Macro REFEREE_STRICT_PRIO_EN: fixed priority (input 0 highest), no rotating pointer.
module rr_arbiter_4 import referee_1_pkg::*; (
    input  logic [NUM_IN-1:0] i_req,
`ifndef REFEREE_STRICT_PRIO_EN
    input  logic [1:0]        i_rr_ptr,
`endif
    output logic [NUM_IN-1:0] o_grant,
    output logic [1:0]        o_idx,
    output logic              o_any
);

    logic [1:0] w_start;
    logic [1:0] w_cand;

`ifdef REFEREE_STRICT_PRIO_EN
    assign w_start = 2'd0;
`else
    assign w_start = i_rr_ptr;
`endif

    // Walk the four candidates starting at w_start; the 2-bit sum wraps for free.
    always_comb begin
        o_grant = '0;
        o_idx   = 2'd0;
        o_any   = 1'b0;
        w_cand  = 2'd0;
        for (int k = 0; k < NUM_IN; k++) begin
            w_cand = w_start + 2'(k);
            if (!o_any && i_req[w_cand]) begin
                o_any          = 1'b1;
                o_idx          = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/referee_1.sv
// 4:1 arbiter feeding the central transaction FIFO: pops one input FIFO per cycle,
// pushes the line two cycles later. Macro REFEREE_STRICT_PRIO_EN selects strict priority.
module referee_1 import referee_1_pkg::*; (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [LINE_SIZE-1:0] data_in0,
    input  logic [LINE_SIZE-1:0] data_in1,
    input  logic [LINE_SIZE-1:0] data_in2,
    input  logic [LINE_SIZE-1:0] data_in3,
    input  logic [NUM_IN-1:0]    empty_signal,
    input  logic                 almost_full_signal,
    output logic [NUM_IN-1:0]    pop_signal,
    output logic                 push_signal,
    output logic [LINE_SIZE-1:0] data_out
);

    logic [NUM_IN-1:0]    w_req;
    logic [NUM_IN-1:0]    w_grant;
    logic [1:0]           w_idx;
    logic                 w_any;
    state_t               r_state;
    state_t               w_state_next;
    logic                 r_vld_p1;
    logic [1:0]           r_sel_p1;
    logic [LINE_SIZE-1:0] w_mux_p1;
    logic                 r_vld_p2;
    logic [LINE_SIZE-1:0] r_data_p2;

    // Almost-full leaves room only for lines already in flight, so it blocks new pops at once.
    assign w_req = ~empty_signal & {NUM_IN{~almost_full_signal & ~reset}};

`ifdef REFEREE_STRICT_PRIO_EN
    rr_arbiter_4 u_arb (
        .i_req   (w_req),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );
`else
    logic [1:0] r_rr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= 2'd0;
        end else if (w_any) begin
            r_rr_ptr <= wrap_inc(w_idx);
        end
    end

    rr_arbiter_4 u_arb (
        .i_req    (w_req),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_grant),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );
`endif

    assign pop_signal = w_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (almost_full_signal)      w_state_next = STALL;
                else if (~&empty_signal)     w_state_next = RUN;
            end
            RUN: begin
                if (almost_full_signal)      w_state_next = STALL;
                else if (&empty_signal)      w_state_next = IDLE;
            end
            STALL: begin
                if (!almost_full_signal)     w_state_next = (&empty_signal) ? IDLE : RUN;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Stage p1: grant registered, the selected FIFO presents its word this cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_any;
        end
    end

    always_ff @(posedge clk) begin
        if (w_any) begin
            r_sel_p1 <= w_idx;
        end
    end

    always_comb begin
        w_mux_p1 = data_in0;
        case (r_sel_p1)
            2'd0:    w_mux_p1 = data_in0;
            2'd1:    w_mux_p1 = data_in1;
            2'd2:    w_mux_p1 = data_in2;
            default: w_mux_p1 = data_in3;
        endcase
    end

    // Stage p2: line captured and pushed to the central FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p2  <= 1'b0;
            r_data_p2 <= '0;
        end else begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_data_p2 <= w_mux_p1;
            end
        end
    end

    assign push_signal = r_vld_p2;
    assign data_out    = r_data_p2;

endmodule

// File: tb/tb_referee_1.sv
// Directed bench for referee_1: models the four registered input FIFOs and checks
// pop order, push data/latency, back-pressure and reset behaviour.
module tb_referee_1;

    logic        clk;
    logic        reset;
    logic [11:0] din [4];
    logic [3:0]  empty;
    logic        af;
    logic [3:0]  pop_signal;
    logic        push_signal;
    logic [11:0] data_out;

    logic [11:0] fq [4][$];
    logic [11:0] got [$];
    int          push_cyc [$];
    logic [11:0] expq [$];
    int          cyc;
    int          n_chk;
    int          n_pass;
    int          c0;

    referee_1 dut (
        .clk                (clk),
        .reset              (reset),
        .data_in0           (din[0]),
        .data_in1           (din[1]),
        .data_in2           (din[2]),
        .data_in3           (din[3]),
        .empty_signal       (empty),
        .almost_full_signal (af),
        .pop_signal         (pop_signal),
        .push_signal        (push_signal),
        .data_out           (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int i, input logic [11:0] w);
        fq[i].push_back(w);
        empty[i] = 1'b0;
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < 4; i++) fq[i].delete();
        empty = 4'b1111;
    endtask

    // One clock: check the combinational pop, clock it, then advance the FIFO model.
    task automatic tick(input logic [3:0] exp_pop, input string tag);
        logic [3:0] p;
        #1;
        p = pop_signal;
        chk(tag, 32'(p), 32'(exp_pop));
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (p[i] && fq[i].size() > 0) din[i] = fq[i].pop_front();
            empty[i] = (fq[i].size() == 0);
        end
        if (push_signal) begin
            got.push_back(data_out);
            push_cyc.push_back(cyc);
        end
    endtask

    task automatic cmp_got(input string tag);
        chk({tag, " count"}, 32'(got.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            chk($sformatf("%s line%0d", tag, i), 32'(got[i]), 32'(expq[i]));
        got.delete();
        push_cyc.delete();
        expq.delete();
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        cyc = 0;
        reset = 1'b1;
        af = 1'b0;
        empty = 4'b1111;
        for (int i = 0; i < 4; i++) din[i] = 12'h000;

        // Reset held with every FIFO non-empty
        for (int i = 0; i < 4; i++) load(i, 12'(32'h100 * (i + 1)));
        for (int k = 0; k < 3; k++) begin
            tick(4'b0000, $sformatf("rst pop c%0d", k));
            chk($sformatf("rst push c%0d", k), 32'(push_signal), 32'd0);
            chk($sformatf("rst data c%0d", k), 32'(data_out), 32'h0);
        end
        reset = 1'b0;
        clear_fifos();
        got.delete();
        push_cyc.delete();
        tick(4'b0000, "idle pop");

        // Round robin across all four, two words each
        for (int i = 0; i < 4; i++) begin
            load(i, 12'(32'h100 * (i + 1)));
            load(i, 12'(32'h100 * (i + 1) + 1));
        end
        c0 = cyc;
        for (int k = 0; k < 8; k++) tick(4'(1 << (k % 4)), $sformatf("rr pop%0d", k));
        for (int k = 0; k < 3; k++) tick(4'b0000, "rr drain");
        if (push_cyc.size() > 0) chk("rr latency", 32'(push_cyc[0] - c0), 32'd2);
        else chk("rr latency", 32'd0, 32'd2);
        chk("rr burst end", 32'(push_cyc.size() == 8 ? push_cyc[7] - push_cyc[0] : 0), 32'd7);
        expq = '{12'h100, 12'h200, 12'h300, 12'h400, 12'h101, 12'h201, 12'h301, 12'h401};
        cmp_got("rr");

        // Single requester granted back to back
        load(2, 12'hA01); load(2, 12'hA02); load(2, 12'hA03);
        for (int k = 0; k < 3; k++) tick(4'b0100, $sformatf("single pop%0d", k));
        for (int k = 0; k < 3; k++) tick(4'b0000, "single drain");
        expq = '{12'hA01, 12'hA02, 12'hA03};
        cmp_got("single");

        // Back-pressure mid-stream; pointer is at 3 here
        load(0, 12'hB00); load(0, 12'hB01);
        load(1, 12'hC00); load(1, 12'hC01);
        load(2, 12'hD00); load(2, 12'hD01);
        tick(4'b0001, "bp pop0");
        tick(4'b0010, "bp pop1");
        af = 1'b1;
        for (int k = 0; k < 3; k++) tick(4'b0000, $sformatf("bp stall%0d", k));
        chk("bp inflight pushes", 32'(got.size()), 32'd2);
        af = 1'b0;
        tick(4'b0100, "bp resume");
        tick(4'b0001, "bp pop3");
        tick(4'b0010, "bp pop4");
        tick(4'b0100, "bp pop5");
        for (int k = 0; k < 3; k++) tick(4'b0000, "bp drain");
        expq = '{12'hB00, 12'hC00, 12'hD00, 12'hB01, 12'hC01, 12'hD01};
        cmp_got("bp");

        // Reset one cycle after a pop discards that line and rewinds the pointer
        load(1, 12'hE00);
        tick(4'b0010, "rstmid pop");
        reset = 1'b1;
        tick(4'b0000, "rstmid pop in reset");
        chk("rstmid push at reset edge", 32'(push_signal), 32'd0);
        chk("rstmid data cleared", 32'(data_out), 32'h0);
        reset = 1'b0;
        clear_fifos();
        tick(4'b0000, "rstmid idle");
        chk("rstmid no late push", 32'(push_signal), 32'd0);
        load(0, 12'hF00);
        load(2, 12'hF02);
        tick(4'b0001, "rstmid first grant");
        tick(4'b0100, "rstmid second grant");
        for (int k = 0; k < 3; k++) tick(4'b0000, "rstmid drain");
        expq = '{12'hF00, 12'hF02};
        cmp_got("rstmid");

        // FIFOs 0 and 3 contending, starting from a fresh pointer
        reset = 1'b1;
        tick(4'b0000, "prio reset");
        reset = 1'b0;
        got.delete();
        push_cyc.delete();
        for (int k = 0; k < 3; k++) begin
            load(0, 12'(32'h010 + k));
            load(3, 12'(32'h030 + k));
        end
`ifdef REFEREE_STRICT_PRIO_EN
        for (int k = 0; k < 3; k++) tick(4'b0001, $sformatf("prio p0 pop%0d", k));
        for (int k = 0; k < 3; k++) tick(4'b1000, $sformatf("prio p3 pop%0d", k));
        expq = '{12'h010, 12'h011, 12'h012, 12'h030, 12'h031, 12'h032};
`else
        for (int k = 0; k < 6; k++) tick((k % 2 == 0) ? 4'b0001 : 4'b1000, $sformatf("prio pop%0d", k));
        expq = '{12'h010, 12'h030, 12'h011, 12'h031, 12'h012, 12'h032};
`endif
        for (int k = 0; k < 3; k++) tick(4'b0000, "prio drain");
        cmp_got("prio");
        chk("final hold data", 32'(data_out), 32'h032);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
